// File: rtl/chronos_pkg.sv
// rtl/chronos_pkg.sv - shared tile addressing types for the chronos tile fabric
package chronos_pkg;
  localparam int N_TILES   = 16;
  localparam int TILE_ID_W = $clog2(N_TILES);
  typedef logic [TILE_ID_W-1:0] tile_id_t;
endpackage

// File: rtl/noc_inj_fifo.sv
// rtl/noc_inj_fifo.sv - per-producer sync FIFO for the tile NoC injector
module noc_inj_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             not_full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push_en;
  logic             pop_en;

  assign push_en = push && not_full;
  assign pop_en  = pop && !empty;
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push_en, pop_en})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  // not_full is registered from the next count, so a slot freed by a pop shows up one cycle later
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_next;
      not_full <= (count_next < CNT_W'(DEPTH));
    end
  end
endmodule

// File: rtl/tile_noc_injector.sv
// rtl/tile_noc_injector.sv - merges local producers onto one tile_noc slave port
// Per-producer FIFOs, round-robin arbiter and a registered output stage held until accepted.
module tile_noc_injector
  import chronos_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_SRC-1:0]    in_valid,
  output logic [NUM_SRC-1:0]    in_ready,
  input  tile_id_t              in_dst  [NUM_SRC],
  input  logic [DATA_WIDTH-1:0] in_data [NUM_SRC],
  output logic                  s_wvalid,
  input  logic                  s_wready,
  output tile_id_t              s_port,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [31:0]           sent_count
);
  localparam int IDX_W = $clog2(NUM_SRC);

  typedef struct packed {
    tile_id_t              dst;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t             head [NUM_SRC];
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] pop;
  logic [IDX_W-1:0]   rr;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   rr_next;
  logic               grant_valid;
  logic               load;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    noc_inj_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .push     (in_valid[i]),
      .pop      (pop[i]),
      .din      ({in_dst[i], in_data[i]}),
      .not_full (in_ready[i]),
      .empty    (empty[i]),
      .head     (head[i])
    );
  end

  // First non-empty FIFO at or after rr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant       = rr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_valid && !empty[(int'(rr) + k) % NUM_SRC]) begin
        grant_valid = 1'b1;
        grant       = IDX_W'((int'(rr) + k) % NUM_SRC);
      end
    end
  end

  assign load    = !s_wvalid || s_wready;
  assign rr_next = (grant == IDX_W'(NUM_SRC - 1)) ? '0 : grant + IDX_W'(1);

  always_comb begin
    pop = '0;
    if (load && grant_valid) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_wvalid   <= 1'b0;
      s_port     <= '0;
      s_wdata    <= '0;
      rr         <= '0;
      sent_count <= '0;
    end else begin
      if (s_wvalid && s_wready) sent_count <= sent_count + 32'd1;
      if (load) begin
        if (grant_valid) begin
          s_wvalid <= 1'b1;
          s_port   <= head[grant].dst;
          s_wdata  <= head[grant].data;
          rr       <= rr_next;
        end else begin
          s_wvalid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_tile_noc_injector.sv
// tb/tb_tile_noc_injector.sv - directed scoreboard bench for tile_noc_injector
module tb_tile_noc_injector;
  import chronos_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int DW      = 32;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NUM_SRC-1:0] in_valid;
  logic [NUM_SRC-1:0] in_ready;
  tile_id_t           in_dst  [NUM_SRC];
  logic [DW-1:0]      in_data [NUM_SRC];
  logic               s_wvalid;
  logic               s_wready;
  tile_id_t           s_port;
  logic [DW-1:0]      s_wdata;
  logic [31:0]        sent_count;

  typedef struct packed {
    tile_id_t      dst;
    logic [DW-1:0] data;
  } exp_t;

  exp_t expq[$];
  int   tests    = 0;
  int   fails    = 0;
  int   exp_sent = 0;

  tile_noc_injector #(
    .NUM_SRC    (NUM_SRC),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dst     (in_dst),
    .in_data    (in_data),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_port     (s_port),
    .s_wdata    (s_wdata),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (rstn === 1'b1 && s_wvalid === 1'b1 && s_wready === 1'b1) begin
      exp_sent++;
      tests++;
      assert (expq.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_msg: observed port %0h data %0h expected no message", s_port, s_wdata);
      end
      if (expq.size() != 0) begin
        exp_t e;
        e = expq.pop_front();
        check("out_port", s_port, e.dst);
        check("out_data", s_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    in_valid = '0;
    tick();
    check("rst_in_ready", in_ready, 4'h0);
    check("rst_wvalid", s_wvalid, 1'b0);
    tick();
    expq.delete();
    exp_sent = 0;
    rstn = 1'b1;
    tick();
    check("rst_in_ready_up", in_ready, 4'hf);
    check("rst_sent", sent_count, 32'd0);
    check("rst_port", s_port, 4'h0);
    check("rst_wdata", s_wdata, 32'h0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((expq.size() != 0 || s_wvalid !== 1'b0) && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, (n < 50), 1'b1);
    check({tag, "_sent"}, sent_count, 32'(exp_sent));
  endtask

  initial begin
    rstn     = 1'b0;
    in_valid = '0;
    s_wready = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      in_dst[i]  = '0;
      in_data[i] = '0;
    end
    do_reset();

    // 1: single message, one-cycle latency
    s_wready    = 1'b1;
    in_valid[0] = 1'b1;
    in_dst[0]   = 4'd1;
    in_data[0]  = 32'hABCDABCD;
    expq.push_back({4'd1, 32'hABCDABCD});
    tick();
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_not_yet", s_wvalid, 1'b0);
    tick();
    check("t1_wvalid", s_wvalid, 1'b1);
    check("t1_wdata", s_wdata, 32'hABCDABCD);
    drain("t1");
    check("t1_sent_one", sent_count, 32'd1);

    // 2: backpressure holds the output stable
    s_wready    = 1'b0;
    in_valid[1] = 1'b1;
    in_dst[1]   = 4'd5;
    in_data[1]  = 32'h2222_5555;
    expq.push_back({4'd5, 32'h2222_5555});
    tick();
    in_valid[1] = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("t2_hold_valid", s_wvalid, 1'b1);
      check("t2_hold_port", s_port, 4'd5);
      check("t2_hold_data", s_wdata, 32'h2222_5555);
      tick();
    end
    check("t2_sent_held", sent_count, 32'd1);
    s_wready = 1'b1;
    drain("t2");

    // 3: all producers at once, rr starts at 0 after reset
    do_reset();
    s_wready = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      in_valid[i] = 1'b1;
      in_dst[i]   = tile_id_t'(i + 8);
      in_data[i]  = 32'h10 + 32'(i);
      expq.push_back({tile_id_t'(i + 8), 32'h10 + 32'(i)});
    end
    tick();
    in_valid = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      tick();
      check("t3_b2b_valid", s_wvalid, 1'b1);
      check("t3_b2b_data", s_wdata, 32'h10 + 32'(i));
    end
    drain("t3");
    // rr must be back at 0: producer 0 beats producer 3
    in_valid    = 4'b1001;
    in_dst[0]   = 4'd0;
    in_data[0]  = 32'h30;
    in_dst[3]   = 4'd3;
    in_data[3]  = 32'h33;
    expq.push_back({4'd0, 32'h30});
    expq.push_back({4'd3, 32'h33});
    tick();
    in_valid = '0;
    drain("t3_rr0");

    // 4: overfill producer 2; output reg takes one, FIFO holds DEPTH more
    s_wready    = 1'b0;
    in_valid[2] = 1'b1;
    in_dst[2]   = 4'd2;
    for (int m = 0; m < DEPTH + 1; m++) begin
      in_data[2] = 32'h4000 + 32'(m);
      check("t4_ready", in_ready[2], 1'b1);
      expq.push_back({4'd2, 32'h4000 + 32'(m)});
      tick();
    end
    in_data[2] = 32'h4000 + 32'(DEPTH + 1);
    check("t4_full", in_ready[2], 1'b0);
    tick();
    check("t4_still_full", in_ready[2], 1'b0);
    check("t4_head_held", s_wdata, 32'h4000);
    s_wready = 1'b1;
    tick();
    check("t4_freed", in_ready[2], 1'b1);
    expq.push_back({4'd2, 32'h4000 + 32'(DEPTH + 1)});
    tick();
    in_valid[2] = 1'b0;
    drain("t4");

    // 5: rr is 3 after granting producer 2; producer 3 wins over 1
    in_valid   = 4'b1010;
    in_dst[1]  = 4'd1;
    in_data[1] = 32'h51;
    in_dst[3]  = 4'd3;
    in_data[3] = 32'h53;
    expq.push_back({4'd3, 32'h53});
    expq.push_back({4'd1, 32'h51});
    tick();
    in_valid = '0;
    tick();
    check("t5_first", s_wdata, 32'h53);
    drain("t5");

    // 6: reset with queued and in-flight messages drops them all
    s_wready = 1'b0;
    in_valid = 4'b0011;
    for (int m = 0; m < 3; m++) begin
      in_data[0] = 32'h6000 + 32'(m);
      in_data[1] = 32'h6100 + 32'(m);
      tick();
    end
    in_valid = '0;
    check("t6_inflight", s_wvalid, 1'b1);
    do_reset();
    s_wready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    check("t6_no_valid", s_wvalid, 1'b0);
    check("t6_sent_zero", sent_count, 32'd0);

    // recovery after reset
    in_valid[3] = 1'b1;
    in_dst[3]   = 4'd3;
    in_data[3]  = 32'hBEEF;
    expq.push_back({4'd3, 32'hBEEF});
    tick();
    in_valid = '0;
    drain("t6_recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
